enc_ctrl_unit: RTL and testbench

Encryption Controller Unit of the AES core: the encrypt-direction counterpart of the decryption controller. On an encrypt request it loads the cipher key into key expansion, performs the round-0 AddRoundKey, and sequences ten round-unit passes via a launch/ready handshake. It then registers the ciphertext and pulses completion. The unit serves two operations: data encryption under a user key, and key wrapping (user key encrypted under the master key).

---
 rtl/enc_ctrl_unit.sv | 164 ++++++++++++++++
 tb/tb_enc_ctrl_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_ctrl_unit.sv
// ============================================================================
// Module   : enc_ctrl_unit
// Brief    : AES-128 encrypt-direction controller: key load, round-0
//            AddRoundKey, round sequencing and ciphertext capture.
// Revision : 1.0
// ============================================================================
`default_nettype none

module enc_ctrl_unit #(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start_op,
    input  logic         ed_sel,
    input  logic         key_op,
    input  logic         key_expanded,
    input  logic         r_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    input  logic [127:0] mk_key,
    input  logic [127:0] round_out,
    output logic         start_key_exp,
    output logic [127:0] e_key,
    output logic [127:0] e_data,
    output logic [3:0]   round_num,
    output logic         round_go,
    output logic         last_round,
    output logic [127:0] ciphertext,
    output logic         enc_done,
    output logic         busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_KEY_EXP = 3'd1;
    localparam logic [2:0] S_ADD0    = 3'd2;
    localparam logic [2:0] S_LAUNCH  = 3'd3;
    localparam logic [2:0] S_WAIT_R  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [3:0] LAST_RND  = 4'(NROUNDS);

    logic [2:0]   state_q, state_d;
    logic [127:0] e_key_q, e_key_d;
    logic [127:0] src_q, src_d;
    logic [127:0] e_data_q, e_data_d;
    logic [127:0] ct_q, ct_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         accept;
    logic         rnd_last;

    // Decrypt requests belong to the sibling controller and are dropped here.
    assign accept   = start_op & ~ed_sel;
    assign rnd_last = (rnd_q == LAST_RND);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_KEY_EXP;
                end
            end
            S_KEY_EXP: begin
                if (key_expanded) begin
                    state_d = S_ADD0;
                end
            end
            S_ADD0: begin
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (r_ready) begin
                    state_d = rnd_last ? S_DONE : S_LAUNCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        start_key_exp = (state_q == S_KEY_EXP);
        round_go      = (state_q == S_LAUNCH);
        enc_done      = (state_q == S_DONE);
        busy          = (state_q != S_IDLE);
        last_round    = rnd_last;
    end

    always_comb begin
        e_key_d  = e_key_q;
        src_d    = src_q;
        e_data_d = e_data_q;
        ct_d     = ct_q;
        rnd_d    = rnd_q;
        case (state_q)
            S_IDLE: begin
                // Key wrap encrypts the user key under the master key.
                if (accept) begin
                    e_key_d = key_op ? mk_key : key_in;
                    src_d   = key_op ? key_in : data_in;
                end
            end
            S_ADD0: begin
                e_data_d = src_q ^ e_key_q;
                rnd_d    = 4'd1;
            end
            S_WAIT_R: begin
                if (r_ready) begin
                    e_data_d = round_out;
                    if (rnd_last) begin
                        ct_d = round_out;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                rnd_d = 4'd0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            e_key_q  <= '0;
            src_q    <= '0;
            e_data_q <= '0;
            ct_q     <= '0;
            rnd_q    <= '0;
        end else begin
            e_key_q  <= e_key_d;
            src_q    <= src_d;
            e_data_q <= e_data_d;
            ct_q     <= ct_d;
            rnd_q    <= rnd_d;
        end
    end

    assign e_key      = e_key_q;
    assign e_data     = e_data_q;
    assign ciphertext = ct_q;
    assign round_num  = rnd_q;

endmodule

`default_nettype wire

// File: tb/tb_enc_ctrl_unit.sv
// ============================================================================
// Module   : tb_enc_ctrl_unit
// Brief    : Directed table-driven bench for enc_ctrl_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_enc_ctrl_unit;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start_op = 1'b0;
    logic         ed_sel = 1'b0;
    logic         key_op = 1'b0;
    logic         key_expanded = 1'b0;
    logic         r_ready = 1'b0;
    logic [127:0] data_in = '0;
    logic [127:0] key_in = '0;
    logic [127:0] mk_key = '0;
    logic [127:0] round_out = '0;
    logic         start_key_exp;
    logic [127:0] e_key;
    logic [127:0] e_data;
    logic [3:0]   round_num;
    logic         round_go;
    logic         last_round;
    logic [127:0] ciphertext;
    logic         enc_done;
    logic         busy;

    enc_ctrl_unit #(.NROUNDS(NR)) dut (
        .clk(clk), .n_rst(n_rst), .start_op(start_op), .ed_sel(ed_sel),
        .key_op(key_op), .key_expanded(key_expanded), .r_ready(r_ready),
        .data_in(data_in), .key_in(key_in), .mk_key(mk_key),
        .round_out(round_out), .start_key_exp(start_key_exp), .e_key(e_key),
        .e_data(e_data), .round_num(round_num), .round_go(round_go),
        .last_round(last_round), .ciphertext(ciphertext),
        .enc_done(enc_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         key_op;
        logic [127:0] key;
        logic [127:0] data;
        logic [127:0] mk;
        logic [127:0] exp_ekey;
        logic [127:0] exp_add0;
        logic [127:0] final_ct;
        int           stall_round;
        int           stall_n;
        bit           noisy;
        bit           poke;
        bit           done_req;
        int           exp_lat;
    } vec_t;

    vec_t  vecs[4];
    int    total = 0;
    int    bad = 0;
    string tag = "";

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %h want %h", tag, name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %b want %b", tag, name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk1("skx", start_key_exp, 1'b0);
        chk1("go", round_go, 1'b0);
        chk1("last", last_round, 1'b0);
        chk1("done", enc_done, 1'b0);
        chk1("busy", busy, 1'b0);
        chkw("rnum", 128'(round_num), 128'd0);
        chkw("ekey", e_key, 128'd0);
        chkw("edata", e_data, 128'd0);
        chkw("ct", ciphertext, 128'd0);
    endtask

    task automatic do_op(input vec_t v, input int abort_round);
        int lat, gos, wait_n;
        bit pending, done_seen, poked;
        logic [127:0] last_ro;
        @(negedge clk);
        start_op = 1'b1; ed_sel = 1'b0; key_op = v.key_op;
        key_in = v.key; data_in = v.data; mk_key = v.mk;
        @(negedge clk);
        start_op = 1'b0;
        chk1("busy_acc", busy, 1'b1);
        chk1("skx_acc", start_key_exp, 1'b1);
        chkw("ekey_acc", e_key, v.exp_ekey);
        repeat (9) @(negedge clk);
        chk1("skx_hold", start_key_exp, 1'b1);
        key_expanded = 1'b1;
        @(negedge clk);
        key_expanded = 1'b0;
        chk1("skx_add0", start_key_exp, 1'b0);
        chk1("busy_add0", busy, 1'b1);
        lat = 1; gos = 0; wait_n = 0; pending = 0; done_seen = 0; poked = 0;
        last_ro = v.exp_add0;
        for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            @(negedge clk);
            lat++;
            r_ready = 1'b0;
            if (poked) start_op = 1'b0;
            if (round_go) begin
                gos++;
                chkw("rnum_go", 128'(round_num), 128'(gos));
                chkw("edata_go", e_data, last_ro);
                if (abort_round == gos) begin
                    n_rst = 1'b0;
                    #1;
                    chk_reset_outputs();
                    repeat (3) begin
                        @(negedge clk);
                        chk1("done_abort", enc_done, 1'b0);
                        chk1("busy_abort", busy, 1'b0);
                    end
                    n_rst = 1'b1;
                    @(negedge clk);
                    chk1("busy_rel", busy, 1'b0);
                    return;
                end
                wait_n = (gos == v.stall_round) ? v.stall_n : 0;
                pending = 1;
                if (v.noisy) begin
                    r_ready = 1'b1;
                    round_out = '1;
                end
            end else if (enc_done) begin
                done_seen = 1;
                chkw("ct_done", ciphertext, v.final_ct);
                chkw("lat", 128'(lat), 128'(v.exp_lat));
                chkw("ngo", 128'(gos), 128'(NR));
                chkw("ekey_done", e_key, v.exp_ekey);
                if (v.done_req) begin
                    start_op = 1'b1;
                    key_in = ~v.key;
                end
            end else if (pending) begin
                chkw("rnum_hold", 128'(round_num), 128'(gos));
                if (v.poke && gos == 5 && !poked) begin
                    poked = 1;
                    start_op = 1'b1; key_op = ~v.key_op;
                    key_in = ~v.key; data_in = ~v.data; mk_key = ~v.mk;
                end
                if (wait_n == 0) begin
                    r_ready = 1'b1;
                    round_out = (gos == NR) ? v.final_ct : {16{8'(gos)}};
                    last_ro = round_out;
                    pending = 0;
                end else begin
                    wait_n--;
                end
            end
            chk1("last", last_round, (gos == NR));
        end
        chk1("done_seen", done_seen, 1'b1);
        @(negedge clk);
        start_op = 1'b0; r_ready = 1'b0;
        chk1("busy_post", busy, 1'b0);
        chk1("done_post", enc_done, 1'b0);
        chkw("rnum_post", 128'(round_num), 128'd0);
        chkw("ct_post", ciphertext, v.final_ct);
        chkw("ekey_post", e_key, v.exp_ekey);
        @(negedge clk);
        chk1("busy_post2", busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff, {4{32'hdeadbeef}},
                    128'h000102030405060708090a0b0c0d0e0f,
                    128'h00102030405060708090a0b0c0d0e0f0,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0, 1'b0, 1'b0, 1'b0, 22};
        // Third byte: 94 ^ ab = 3f.
        vecs[1] = '{1'b1, 128'h97049427aad9b15464867349d2da88aa,
                    {4{32'h12345678}}, {16{8'hab}}, {16{8'hab}},
                    128'h3caf3f8c01721affcf2dd8e279712301,
                    128'hfedcba98765432100123456789abcdef, 4, 4, 1'b0, 1'b0, 1'b0, 26};
        vecs[2] = '{1'b0, {16{8'hff}}, {16{8'h0f}}, {16{8'h11}}, {16{8'hff}},
                    {16{8'hf0}}, {16{8'h5a}}, 0, 0, 1'b1, 1'b0, 1'b1, 22};
        vecs[3] = '{1'b0, {4{32'h0000ffff}}, {4{32'h00ff00ff}}, {4{32'h77777777}},
                    {4{32'h0000ffff}}, {4{32'h00ffff00}}, {4{32'hc3c3c3c3}},
                    0, 0, 1'b0, 1'b1, 1'b0, 22};

        tag = "reset";
        start_op = 1'b1; key_expanded = 1'b1; r_ready = 1'b1;
        key_in = {4{32'hcafef00d}}; data_in = {4{32'h0badc0de}};
        mk_key = {4{32'h13579bdf}}; round_out = {4{32'h2468ace0}};
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        start_op = 1'b0; key_expanded = 1'b0; r_ready = 1'b0;
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk1("busy_rel", busy, 1'b0);
        chkw("rnum_rel", 128'(round_num), 128'd0);

        for (int i = 0; i < 4; i++) begin
            tag = $sformatf("vec%0d", i);
            do_op(vecs[i], 0);
        end

        tag = "edsel";
        @(negedge clk);
        start_op = 1'b1; ed_sel = 1'b1;
        @(negedge clk);
        start_op = 1'b0; ed_sel = 1'b0;
        chk1("busy", busy, 1'b0);
        chk1("skx", start_key_exp, 1'b0);
        @(negedge clk);
        chk1("busy2", busy, 1'b0);

        tag = "abort";
        do_op(vecs[0], 6);

        tag = "after_abort";
        begin
            vec_t v;
            v = vecs[1];
            v.stall_round = 0; v.stall_n = 0; v.exp_lat = 22;
            do_op(v, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
